// File: rtl/pmod_ssd_mux_driver.sv
// Two-digit hex display multiplexer with inter-digit blanking and a per-frame shadow of the value.
// Outputs registered; one frame = 2*(REFRESH_DIV+BLANK_CYCLES) cycles, no backpressure.
module pmod_ssd_mux_driver #(
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int LZ_BLANK       = 0
) (
  input  logic       S_AXI_ACLK,
  input  logic       S_AXI_ARESETN,
  input  logic [7:0] disp_value,
  input  logic       value_wr,
  input  logic       disp_enable,
  output logic [6:0] ssd_seg,
  output logic       ssd_sel,
  output logic       frame_done
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [6:0]    SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [2:0] {IDLE, SHOW_LO, BLANK_LO, SHOW_HI, BLANK_HI} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    pend_q, pend_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [6:0]    seg_q, seg_d;
  logic          sel_q, sel_d;
  logic          fd_q, fd_d;
  logic [6:0]    seg_raw;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (disp_enable) state_d = SHOW_LO;
      SHOW_LO:  if (cnt_q == SHOW_LAST) state_d = (BLANK_CYCLES == 0) ? SHOW_HI : BLANK_LO;
      BLANK_LO: if (cnt_q == BLANK_LAST) state_d = SHOW_HI;
      SHOW_HI:  if (cnt_q == SHOW_LAST) state_d = (BLANK_CYCLES == 0) ? SHOW_LO : BLANK_HI;
      BLANK_HI: if (cnt_q == BLANK_LAST) state_d = SHOW_LO;
      default:  state_d = IDLE;
    endcase
    if (!disp_enable) state_d = IDLE;

    cnt_d  = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    pend_d = value_wr ? disp_value : pend_q;

    // A write landing on the frame boundary must win over the older pending value.
    shadow_d = shadow_q;
    if (state_d == SHOW_LO && state_q != SHOW_LO)
      shadow_d = value_wr ? disp_value : pend_q;

    fd_d = (state_d == SHOW_LO) && (state_q == BLANK_HI || state_q == SHOW_HI);

    seg_raw = 7'h00;
    case (state_d)
      SHOW_LO: seg_raw = hex7(shadow_d[3:0]);
      SHOW_HI: if (!(LZ_BLANK != 0 && shadow_d[7:4] == 4'h0)) seg_raw = hex7(shadow_d[7:4]);
      default: seg_raw = 7'h00;
    endcase
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    sel_d = (state_d == SHOW_HI) || (state_d == BLANK_HI);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= 8'h00;
      shadow_q <= 8'h00;
      seg_q    <= SEG_OFF;
      sel_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      fd_q     <= fd_d;
    end
  end

  assign ssd_seg    = seg_q;
  assign ssd_sel    = sel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_pmod_ssd_mux_driver.sv
// Bench for pmod_ssd_mux_driver: three parameterisations share one stimulus stream and are
// compared every cycle against a phase-arithmetic model, plus directed sequences and a decode table.
module tb_pmod_ssd_mux_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] disp_value = 8'h00;
  logic       value_wr = 1'b0;
  logic       disp_enable = 1'b0;
  logic [6:0] a_seg [3];
  logic       a_sel [3];
  logic       a_fd  [3];

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pmod_ssd_mux_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0), .LZ_BLANK(0)) u0 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .disp_value(disp_value), .value_wr(value_wr),
    .disp_enable(disp_enable), .ssd_seg(a_seg[0]), .ssd_sel(a_sel[0]), .frame_done(a_fd[0]));
  pmod_ssd_mux_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0), .LZ_BLANK(1)) u1 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .disp_value(disp_value), .value_wr(value_wr),
    .disp_enable(disp_enable), .ssd_seg(a_seg[1]), .ssd_sel(a_sel[1]), .frame_done(a_fd[1]));
  pmod_ssd_mux_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1), .LZ_BLANK(0)) u2 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .disp_value(disp_value), .value_wr(value_wr),
    .disp_enable(disp_enable), .ssd_seg(a_seg[2]), .ssd_sel(a_sel[2]), .frame_done(a_fd[2]));

  // Model: parameters per instance and the hex glyph table.
  int         m_r  [3] = '{4, 4, 4};
  int         m_b  [3] = '{2, 2, 0};
  bit         m_lz [3] = '{1'b0, 1'b1, 1'b0};
  bit         m_al [3] = '{1'b0, 1'b0, 1'b1};
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  bit         m_run  [3] = '{1'b0, 1'b0, 1'b0};
  int         m_t    [3] = '{0, 0, 0};
  logic [7:0] m_pend [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] m_shad [3] = '{8'h00, 8'h00, 8'h00};
  logic [6:0] e_seg  [3] = '{7'h00, 7'h00, 7'h7F};
  logic       e_sel  [3] = '{1'b0, 1'b0, 1'b0};
  logic       e_fd   [3] = '{1'b0, 1'b0, 1'b0};

  function automatic logic [6:0] pin(input int k, input logic [6:0] raw);
    return m_al[k] ? ~raw : raw;
  endfunction

  // Time since the start of the current display run, folded into the frame period.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_run[k] = 1'b0; m_t[k] = 0; m_pend[k] = 8'h00; m_shad[k] = 8'h00;
        e_seg[k] = pin(k, 7'h00); e_sel[k] = 1'b0; e_fd[k] = 1'b0;
      end else begin
        int p;
        int period;
        period = 2 * (m_r[k] + m_b[k]);
        e_fd[k] = 1'b0;
        if (!disp_enable) m_run[k] = 1'b0;
        else begin
          if (!m_run[k]) begin m_run[k] = 1'b1; m_t[k] = 0; end
          else begin
            m_t[k] = m_t[k] + 1;
            if (m_t[k] == period) begin m_t[k] = 0; e_fd[k] = 1'b1; end
          end
          if (m_t[k] == 0) m_shad[k] = value_wr ? disp_value : m_pend[k];
        end
        if (value_wr) m_pend[k] = disp_value;
        p = m_t[k];
        e_seg[k] = pin(k, 7'h00);
        e_sel[k] = 1'b0;
        if (m_run[k]) begin
          if (p < m_r[k]) e_seg[k] = pin(k, hex_tab[m_shad[k][3:0]]);
          else if (p >= m_r[k] + m_b[k]) begin
            e_sel[k] = 1'b1;
            if (p < 2 * m_r[k] + m_b[k] && !(m_lz[k] && m_shad[k][7:4] == 4'h0))
              e_seg[k] = pin(k, hex_tab[m_shad[k][7:4]]);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model u%0d seg", k), 32'(a_seg[k]), 32'(e_seg[k]));
        check($sformatf("model u%0d sel", k), 32'(a_sel[k]), 32'(e_sel[k]));
        check($sformatf("model u%0d frame_done", k), 32'(a_fd[k]), 32'(e_fd[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Restart the display from IDLE with a value written on the enabling edge.
  task automatic restart(input logic [7:0] v);
    disp_enable = 1'b0; value_wr = 1'b0;
    tick();
    disp_value = v; value_wr = 1'b1; disp_enable = 1'b1;
    tick();
    value_wr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] val;
    logic [6:0] exp_lo;
    logic [6:0] exp_hi;
  } dec_vec_t;

  dec_vec_t dec_tab [8];

  initial begin
    int p;
    dec_tab[0] = '{8'h10, 7'h3F, 7'h06};
    dec_tab[1] = '{8'h32, 7'h5B, 7'h4F};
    dec_tab[2] = '{8'h54, 7'h66, 7'h6D};
    dec_tab[3] = '{8'h76, 7'h7D, 7'h07};
    dec_tab[4] = '{8'h98, 7'h7F, 7'h6F};
    dec_tab[5] = '{8'hBA, 7'h77, 7'h7C};
    dec_tab[6] = '{8'hDC, 7'h39, 7'h5E};
    dec_tab[7] = '{8'hFE, 7'h79, 7'h71};

    // Reset held low.
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check("reset u0 seg", 32'(a_seg[0]), 32'h00);
    check("reset u0 sel", 32'(a_sel[0]), 32'h0);
    check("reset u0 frame_done", 32'(a_fd[0]), 32'h0);
    check("reset u2 seg", 32'(a_seg[2]), 32'h7F);
    @(negedge clk); #1 rst_n = 1'b1;

    // Value 0x3A: two full frames of the nominal sequence.
    disp_value = 8'h3A; value_wr = 1'b1;
    tick();
    value_wr = 1'b0; disp_enable = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) begin
      p = i % 12;
      check("seq 3A seg", 32'(a_seg[0]), (p < 4) ? 32'h77 : (p >= 6 && p < 10) ? 32'h4F : 32'h00);
      check("seq 3A sel", 32'(a_sel[0]), (p >= 6) ? 32'h1 : 32'h0);
      check("seq 3A frame_done", 32'(a_fd[0]), (i > 0 && p == 0) ? 32'h1 : 32'h0);
      tick();
    end

    // Write 0x5B during SHOW_HI: current frame untouched, next frame shows it.
    repeat (6) tick();
    check("midwrite hi before", 32'(a_seg[0]), 32'h4F);
    disp_value = 8'h5B; value_wr = 1'b1;
    tick();
    value_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("midwrite hi held", 32'(a_seg[0]), 32'h4F);
      tick();
    end
    repeat (2) tick();
    check("midwrite next lo", 32'(a_seg[0]), 32'h7C);
    check("midwrite next frame_done", 32'(a_fd[0]), 32'h1);
    repeat (6) tick();
    check("midwrite next hi", 32'(a_seg[0]), 32'h6D);
    check("midwrite next sel", 32'(a_sel[0]), 32'h1);

    // Leading-zero blanking on u1 with 0x07 (written on the enabling edge).
    restart(8'h07);
    for (int i = 0; i <= 12; i++) begin
      p = i % 12;
      check("lz seg", 32'(a_seg[1]), (p < 4) ? 32'h07 : 32'h00);
      check("lz sel", 32'(a_sel[1]), (p >= 6) ? 32'h1 : 32'h0);
      check("lz frame_done", 32'(a_fd[1]), (i == 12) ? 32'h1 : 32'h0);
      if (i < 12) tick();
    end

    // Disable in the 2nd SHOW_LO cycle, then re-enable.
    tick();
    disp_enable = 1'b0;
    tick();
    check("disable seg", 32'(a_seg[0]), 32'h00);
    check("disable sel", 32'(a_sel[0]), 32'h0);
    check("disable frame_done", 32'(a_fd[0]), 32'h0);
    disp_enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("reenable seg", 32'(a_seg[0]), (i < 4) ? 32'h07 : 32'h00);
      check("reenable sel", 32'(a_sel[0]), 32'h0);
      tick();
    end

    // u2: no blank phase, active-low pins, 0x88.
    restart(8'h88);
    for (int i = 0; i < 16; i++) begin
      check("noblank seg", 32'(a_seg[2]), 32'h00);
      check("noblank sel", 32'(a_sel[2]), 32'((i / 4) % 2));
      check("noblank frame_done", 32'(a_fd[2]), (i > 0 && i % 8 == 0) ? 32'h1 : 32'h0);
      tick();
    end
    disp_enable = 1'b0;
    tick();
    check("noblank off seg", 32'(a_seg[2]), 32'h7F);
    check("noblank off sel", 32'(a_sel[2]), 32'h0);

    // Decode table across all sixteen nibbles.
    for (int r = 0; r < 8; r++) begin
      restart(dec_tab[r].val);
      check($sformatf("decode lo %02h", dec_tab[r].val), 32'(a_seg[0]), 32'(dec_tab[r].exp_lo));
      repeat (6) tick();
      check($sformatf("decode hi %02h", dec_tab[r].val), 32'(a_seg[0]), 32'(dec_tab[r].exp_hi));
      check($sformatf("decode sel %02h", dec_tab[r].val), 32'(a_sel[0]), 32'h1);
    end

    // Asynchronous reset in the middle of SHOW_HI.
    restart(8'h3A);
    repeat (6) tick();
    check("pre-reset hi", 32'(a_seg[0]), 32'h4F);
    rst_n = 1'b0;
    #1;
    check("async reset seg", 32'(a_seg[0]), 32'h00);
    check("async reset sel", 32'(a_sel[0]), 32'h0);
    check("async reset frame_done", 32'(a_fd[0]), 32'h0);
    check("async reset u2 seg", 32'(a_seg[2]), 32'h7F);
    @(negedge clk); #1 rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      disp_value  = 8'($urandom);
      value_wr    = ($urandom_range(0, 5) == 0);
      disp_enable = ($urandom_range(0, 59) != 0);
    end
    tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
